// File: rtl/ysyx_23060184_idu_ctrl_pkg.sv
// Shared constants for the decode-stage controller: widths, ExtOp codes,
// opcodes and the special instruction encodings.
package ysyx_23060184_idu_ctrl_pkg;

    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned EXT_OP_LENGTH = 3;
    localparam int unsigned OPCODE_WIDTH  = 7;

    typedef enum logic [EXT_OP_LENGTH-1:0] {
        EXT_OP_I    = 3'd0,
        EXT_OP_U    = 3'd1,
        EXT_OP_S    = 3'd2,
        EXT_OP_B    = 3'd3,
        EXT_OP_J    = 3'd4,
        EXT_OP_NONE = 3'd7
    } ext_op_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } idu_state_e;

    localparam logic [OPCODE_WIDTH-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPCODE_WIDTH-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_WIDTH-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPCODE_WIDTH-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPCODE_WIDTH-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPCODE_WIDTH-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OPCODE_WIDTH-1:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [OPCODE_WIDTH-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPCODE_WIDTH-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPCODE_WIDTH-1:0] OPC_OP     = 7'b0110011;

    localparam logic [DATA_WIDTH-1:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [DATA_WIDTH-1:0] INST_NOP    = 32'h0000_0013;

endpackage

// File: rtl/ysyx_23060184_idu_ctrl_if.sv
// IFU -> IDU -> EXU handshake bundle; master is the surrounding pipeline,
// slave is the decode-stage controller.
interface ysyx_23060184_idu_ctrl_if;
    import ysyx_23060184_idu_ctrl_pkg::*;

    logic                     ifu_valid;
    logic                     ifu_ready;
    logic [DATA_WIDTH-1:0]    ifu_inst;
    logic [DATA_WIDTH-1:0]    ifu_pc;
    logic                     idu_valid;
    logic                     exu_ready;
    logic [DATA_WIDTH-1:0]    idu_inst;
    logic [DATA_WIDTH-1:0]    idu_pc;
    logic [EXT_OP_LENGTH-1:0] ext_op;
    logic                     illegal;
    logic                     flush;
    logic                     halted;

    modport master (
        output ifu_valid, ifu_inst, ifu_pc, exu_ready, flush,
        input  ifu_ready, idu_valid, idu_inst, idu_pc, ext_op, illegal, halted
    );

    modport slave (
        input  ifu_valid, ifu_inst, ifu_pc, exu_ready, flush,
        output ifu_ready, idu_valid, idu_inst, idu_pc, ext_op, illegal, halted
    );

endinterface

// File: rtl/ysyx_23060184_idu_opdec.sv
// Combinational opcode -> {ExtOp, illegal} table, shared with EXU control.
module ysyx_23060184_idu_opdec
    import ysyx_23060184_idu_ctrl_pkg::*;
(
    input  logic [OPCODE_WIDTH-1:0]  i_opcode,
    output logic [EXT_OP_LENGTH-1:0] o_ext_op,
    output logic                     o_illegal
);

    always_comb begin
        o_ext_op  = EXT_OP_NONE;
        o_illegal = 1'b0;
        case (i_opcode)
            OPC_LUI, OPC_AUIPC:                        o_ext_op = EXT_OP_U;
            OPC_JAL:                                   o_ext_op = EXT_OP_J;
            OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_SYSTEM: o_ext_op = EXT_OP_I;
            OPC_BRANCH:                                o_ext_op = EXT_OP_B;
            OPC_STORE:                                 o_ext_op = EXT_OP_S;
            OPC_OP:                                    o_ext_op = EXT_OP_NONE;
            default:                                   o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ysyx_23060184_idu_ctrl.sv
// Decode-stage controller: single-entry stage register between IFU and EXU
// with flush, sticky ebreak halt, and opcode decode for the immediate extender.
module ysyx_23060184_idu_ctrl
    import ysyx_23060184_idu_ctrl_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    ysyx_23060184_idu_ctrl_if.slave       bus
);

    idu_state_e            r_state;
    idu_state_e            w_state_nxt;
    logic                  r_valid;
    logic                  w_valid_nxt;
    logic [DATA_WIDTH-1:0] r_inst;
    logic [DATA_WIDTH-1:0] w_inst_nxt;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] w_pc_nxt;

    logic w_ready;
    logic w_fire_in;
    logic w_fire_out;

    assign w_ready    = (r_state == ST_RUN) && (!r_valid || bus.exu_ready) && !bus.flush;
    assign w_fire_in  = bus.ifu_valid && w_ready;
    assign w_fire_out = r_valid && bus.exu_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_valid <= 1'b0;
            r_inst  <= INST_NOP;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            r_inst  <= w_inst_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Flush wins over an incoming fire; the halt is taken when ebreak leaves for EXU.
    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_inst_nxt  = r_inst;
        w_pc_nxt    = r_pc;

        if (bus.flush) begin
            w_valid_nxt = 1'b0;
        end else if (w_fire_in) begin
            w_valid_nxt = 1'b1;
            w_inst_nxt  = bus.ifu_inst;
            w_pc_nxt    = bus.ifu_pc;
        end else if (w_fire_out) begin
            w_valid_nxt = 1'b0;
        end

        case (r_state)
            ST_RUN:  if (w_fire_out && (r_inst == INST_EBREAK)) w_state_nxt = ST_HALT;
            ST_HALT: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    ysyx_23060184_idu_opdec u_opdec (
        .i_opcode  (r_inst[OPCODE_WIDTH-1:0]),
        .o_ext_op  (bus.ext_op),
        .o_illegal (bus.illegal)
    );

    assign bus.ifu_ready = w_ready;
    assign bus.idu_valid = r_valid;
    assign bus.idu_inst  = r_inst;
    assign bus.idu_pc    = r_pc;
    assign bus.halted    = (r_state == ST_HALT);

endmodule

// File: tb/tb_ysyx_23060184_idu_ctrl.sv
// Directed bench for the decode-stage controller: throughput, backpressure,
// flush, illegal decode, ebreak halt and reset mid-stall.
module tb_ysyx_23060184_idu_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    ysyx_23060184_idu_ctrl_if bus ();

    ysyx_23060184_idu_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
        bus.ifu_valid = 1'b1;
        bus.ifu_inst  = inst;
        bus.ifu_pc    = pc;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.ifu_valid = 1'b0;
        bus.ifu_inst  = 32'h0;
        bus.ifu_pc    = 32'h0;
        bus.exu_ready = 1'b0;
        bus.flush     = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;

        // reset state
        check("rst_valid",   32'(bus.idu_valid), 32'd0);
        check("rst_inst",    bus.idu_inst,       32'h0000_0013);
        check("rst_pc",      bus.idu_pc,         32'h0);
        check("rst_halted",  32'(bus.halted),    32'd0);
        check("rst_ext_op",  32'(bus.ext_op),    32'd0);
        check("rst_illegal", 32'(bus.illegal),   32'd0);
        check("rst_ready",   32'(bus.ifu_ready), 32'd1);

        // full throughput: I, U, J
        bus.exu_ready = 1'b1;
        offer(32'h0050_0093, 32'h8000_0000);
        step();
        check("tp0_valid",  32'(bus.idu_valid), 32'd1);
        check("tp0_inst",   bus.idu_inst,       32'h0050_0093);
        check("tp0_pc",     bus.idu_pc,         32'h8000_0000);
        check("tp0_ext_op", 32'(bus.ext_op),    32'd0);
        offer(32'h0000_12b7, 32'h8000_0004);
        step();
        check("tp1_inst",   bus.idu_inst,       32'h0000_12b7);
        check("tp1_ext_op", 32'(bus.ext_op),    32'd1);
        offer(32'h0040_006f, 32'h8000_0008);
        step();
        check("tp2_inst",   bus.idu_inst,       32'h0040_006f);
        check("tp2_pc",     bus.idu_pc,         32'h8000_0008);
        check("tp2_ext_op", 32'(bus.ext_op),    32'd4);
        check("tp2_ready",  32'(bus.ifu_ready), 32'd1);

        // backpressure with a store held
        offer(32'h0011_2623, 32'h8000_000c);
        step();
        bus.exu_ready = 1'b0;
        offer(32'h0000_0033, 32'h8000_0010);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("bp_ready",  32'(bus.ifu_ready), 32'd0);
            check("bp_inst",   bus.idu_inst,       32'h0011_2623);
            check("bp_ext_op", 32'(bus.ext_op),    32'd2);
            check("bp_valid",  32'(bus.idu_valid), 32'd1);
            step();
        end
        bus.exu_ready = 1'b1;
        #1;
        check("bp_rel_ready", 32'(bus.ifu_ready), 32'd1);
        step();
        check("add_inst",    bus.idu_inst,     32'h0000_0033);
        check("add_pc",      bus.idu_pc,       32'h8000_0010);
        check("add_ext_op",  32'(bus.ext_op),  32'd7);
        check("add_illegal", 32'(bus.illegal), 32'd0);

        // illegal opcode
        offer(32'h0000_007f, 32'h8000_0014);
        step();
        check("ill_ext_op",  32'(bus.ext_op),  32'd7);
        check("ill_illegal", 32'(bus.illegal), 32'd1);

        // flush while a branch is held and a new inst is offered
        offer(32'hfe07_18e3, 32'h8000_0018);
        step();
        check("br_ext_op", 32'(bus.ext_op),    32'd3);
        check("br_valid",  32'(bus.idu_valid), 32'd1);
        bus.exu_ready = 1'b0;
        bus.flush     = 1'b1;
        offer(32'h0050_0093, 32'h8000_001c);
        #1;
        check("fl_ready", 32'(bus.ifu_ready), 32'd0);
        step();
        bus.flush = 1'b0;
        check("fl_valid", 32'(bus.idu_valid), 32'd0);
        check("fl_inst",  bus.idu_inst,       32'hfe07_18e3);

        // ebreak stalled two cycles, then transferred
        offer(32'h0010_0073, 32'h8000_0020);
        step();
        offer(32'h0000_0013, 32'h8000_0024);
        for (int i = 0; i < 2; i++) begin
            check("eb_stall_halted", 32'(bus.halted),    32'd0);
            check("eb_stall_valid",  32'(bus.idu_valid), 32'd1);
            step();
        end
        bus.ifu_valid = 1'b0;
        bus.exu_ready = 1'b1;
        step();
        check("halt_halted", 32'(bus.halted),    32'd1);
        check("halt_valid",  32'(bus.idu_valid), 32'd0);
        offer(32'h0000_0013, 32'h8000_0024);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("halt_ready", 32'(bus.ifu_ready), 32'd0);
            step();
        end
        check("halt_hold_valid", 32'(bus.idu_valid), 32'd0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("halt_flush_halted", 32'(bus.halted), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("halt_rst_halted", 32'(bus.halted), 32'd0);
        #1;
        check("halt_rst_ready", 32'(bus.ifu_ready), 32'd1);

        // reset during a stall drops the held instruction
        bus.exu_ready = 1'b0;
        offer(32'h0000_0297, 32'h0000_0100);
        step();
        step();
        check("rs_stall_valid", 32'(bus.idu_valid), 32'd1);
        check("rs_stall_pc",    bus.idu_pc,         32'h0000_0100);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rs_valid", 32'(bus.idu_valid), 32'd0);
        check("rs_inst",  bus.idu_inst,       32'h0000_0013);
        check("rs_pc",    bus.idu_pc,         32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ysyx_23060184_idu_ctrl.md
Name: ysyx_23060184_idu_ctrl

Overview:
- Decode-stage pipeline controller between IFU and EXU.
- Accepts one instruction per cycle over a valid/ready handshake and holds it in a single-entry stage register.
- Decodes the opcode into the ExtOp select that drives the immediate extender, plus an illegal-instruction flag.
- Handles flushes from branch redirect, and an ebreak halt state that stops further acceptance.

Parameters:
- DATA_WIDTH, 32, instruction/PC width.
- EXT_OP_LENGTH, 3, width of ExtOp.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- ifu_valid  input  1  IFU presents an instruction
- ifu_ready  output  1  IDU can accept this cycle
- ifu_inst  input  32  fetched instruction
- ifu_pc  input  32  PC of fetched instruction
- idu_valid  output  1  stage register holds a valid instruction
- exu_ready  input  1  EXU accepts this cycle
- idu_inst  output  32  registered instruction (feeds the extender's Inst input)
- idu_pc  output  32  registered PC
- ext_op  output  3  ExtOp for the extender, decoded from idu_inst
- illegal  output  1  idu_inst opcode unsupported (qualified by idu_valid)
- flush  input  1  redirect: discard the held and incoming instruction
- halted  output  1  ebreak has retired out of IDU; core is stopped

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: idu_valid=0, idu_inst=32'h0000_0013 (nop), idu_pc=0, halted=0, state=RUN. ext_op and illegal are combinational from idu_inst; after reset they read EXT_OP_I and 0.
- States:
  - RUN: normal operation.
  - HALT: entered on the cycle an ebreak (32'h0010_0073) transfers to EXU. Sticky until rst.
- Handshake:
  - ifu_ready = (state==RUN) && (!idu_valid || exu_ready) && !flush.
  - Fire_in = ifu_valid && ifu_ready. Fire_out = idu_valid && exu_ready.
  - Register update on Fire_in: load inst/pc, set idu_valid=1 (same cycle as Fire_out allowed → full throughput, 1-cycle latency).
  - Fire_out without Fire_in: idu_valid=0.
  - Stall (idu_valid && !exu_ready): inst/pc/idu_valid held stable.
  - idu_valid never deasserts without Fire_out or flush.
- Flush:
  - Next cycle idu_valid=0. The IFU input that cycle is not accepted (ifu_ready=0).
  - Flush overrides Fire_in.
  - Flush in HALT has no effect on state.
- Halt:
  - On Fire_out of ebreak: state→HALT, halted=1 next cycle, ifu_ready held 0.
  - An ebreak stalled in the register does not halt until transferred.
- ext_op decode (opcode = idu_inst[6:0]):
  - 0110111, 0010111 → U
  - 1101111 → J
  - 1100111, 0000011, 0010011, 1110011 → I
  - 1100011 → B
  - 0100011 → S
  - 0110011 → NONE
  - anything else → NONE with illegal=1
- illegal is only meaningful when idu_valid=1; the EXU ignores it otherwise.
- Reset mid-stall or mid-halt: all state returns to reset values next cycle; the held instruction is lost.

Decomposition:
- Shared package/defines header:
  - DATA_WIDTH, EXT_OP_LENGTH.
  - EXT_OP_I=3'd0, EXT_OP_U=3'd1, EXT_OP_S=3'd2, EXT_OP_B=3'd3, EXT_OP_J=3'd4, EXT_OP_NONE=3'd7.
  - Opcode constants; EBREAK encoding; NOP encoding.
- One natural sub-module: ysyx_23060184_idu_opdec, the combinational opcode → {ext_op, illegal} table, so the table can be reused by the EXU control.
- The existing extender is instantiated by the parent, not inside this block.

Test Plan:
- Throughput: ifu_valid=1 every cycle, exu_ready=1, insts 0x00500093 / 0x000012b7 / 0x0040006f → idu_valid from cycle 1, one per cycle, ext_op I, U, J in order.
- Backpressure: hold exu_ready=0 for 3 cycles with 0x00112623 held → idu_inst stable, ext_op=S, ifu_ready=0. Release → next inst loads the same cycle.
- Flush: flush=1 while 0xfe0718e3 valid and a new inst offered → next cycle idu_valid=0, offered inst not accepted.
- Illegal: opcode 7'b1111111 → ext_op=NONE, illegal=1. Opcode 0110011 (add) → ext_op=NONE, illegal=0.
- Halt: ebreak 0x00100073 stalled 2 cycles (halted stays 0), then exu_ready=1 → halted=1 next cycle, ifu_ready=0 forever. flush ignored; rst=1 clears halted.
- Reset mid-operation: rst=1 while idu_valid=1 and exu_ready=0 → next cycle idu_valid=0, idu_inst=0x00000013, idu_pc=0.
